register_file: RTL and testbench
================================

// Module: register_file
//
// PURPOSE
// - Integer register file for the RV32I core: 32 x 32-bit registers, two read ports, one write port.
// - Sits in the decode stage: supplies rs1/rs2 operands and takes the write-back result on rd.
// - x0 is hardwired to zero. Reads are combinational; writes commit on the rising clock edge.
//
// PARAMETERS
// - DATA_WIDTH  32  width of each register and of the data ports
// - ADDR_WIDTH  5   register index width; depth = 2**ADDR_WIDTH = 32
// - BYPASS      1   1: a read of the register being written returns wr_data_i in the same cycle
//
// PORTS
// - clock_i          in   1   single clock, rising edge active
// - reset_i          in   1   synchronous, active-high reset
// - reg_write_i      in   1   write enable
// - rd_register_1_i  in   5   read port 1 index (rs1)
// - rd_register_2_i  in   5   read port 2 index (rs2)
// - wr_register_i    in   5   write index (rd)
// - wr_data_i        in   32  write data
// - rd_data_1_o      out  32  read port 1 data
// - rd_data_2_o      out  32  read port 2 data
// - Interface: one clock; reset is synchronous and active-high.
//
// BEHAVIOUR
// - Storage: regs[0..31], 32 bits each.
// - Reset: on a rising edge with reset_i=1, all 32 registers clear to 0. Reset overrides reg_write_i.
//   Both read outputs then read 0 for every index.
// - Write: on a rising edge with reset_i=0, reg_write_i=1 and wr_register_i!=0:
//   regs[wr_register_i] <= wr_data_i. The new value is visible in the array one edge after the write.
// - Writes to index 0 are discarded. regs[0] always reads 0.
// - With reg_write_i=0 no register changes; wr_register_i and wr_data_i are don't-care.
// - Read: rd_data_N_o = 0 if rd_register_N_i==0, else regs[rd_register_N_i].
//   Reads are purely combinational with zero latency and have no clock or enable.
// - Bypass (BYPASS=1): if reg_write_i=1, reset_i=0, wr_register_i!=0 and
//   wr_register_i==rd_register_N_i, then rd_data_N_o = wr_data_i combinationally
//   (write-first). Both ports may bypass at the same time.
// - With BYPASS=0, the old contents are returned until the edge.
// - Both ports may address the same register; each port returns identical data.
// - Reset asserted mid-write: the write is lost and the register becomes 0.
//   No bypass occurs while reset_i=1.
// - Outputs before the first reset are undefined (X allowed in simulation).
// - No other state machine or handshake exists.
//
// TESTING
// - Reset: hold reset_i=1 for 1 or more edges, release.
//   Read x1/x2 -> both rd_data = 0x00000000.
// - Write/read: write x1=0x55555555 (we=1), then write x2=0xAAAAAAAA.
//   rd1=x2 -> 0xAAAAAAAA; rd2=x1 -> 0x55555555.
// - Write disable: we=0, wr_register=x1, wr_data=0xAAAAAAAA for 2 edges.
//   x1 stays 0x55555555; x2 stays 0xAAAAAAAA.
// - x0: we=1, wr_register=0, wr_data=0xFFFFFFFF.
//   rd_register_1=0 -> 0x00000000 before and after the edge.
// - Bypass: we=1, wr_register=x5, wr_data=0x12345678, rd_register_1=rd_register_2=x5.
//   Both outputs read 0x12345678 before the edge and keep it after we drops.
// - Reset priority: reset_i=1 and we=1 writing x3=0xDEADBEEF on the same edge.
//   x3 reads 0 afterwards; all other registers read 0.

Source files
------------

// File: rtl/register_file.sv
// Integer register file: 32 x 32-bit, two combinational read ports, one
// clocked write port, x0 hardwired to zero, optional write-first bypass.
module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  reg_write_i,
  input  logic [ADDR_WIDTH-1:0] rd_register_1_i,
  input  logic [ADDR_WIDTH-1:0] rd_register_2_i,
  input  logic [ADDR_WIDTH-1:0] wr_register_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_1_o,
  output logic [DATA_WIDTH-1:0] rd_data_2_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic                  wr_en;

  // A write only takes effect outside reset and never to x0.
  assign wr_en = reg_write_i && !reset_i && (wr_register_i != '0);

  // Storage update: reset clears everything and wins over a write.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      regs_q <= '{default: '0};
    end else if (wr_en) begin
      regs_q[wr_register_i] <= wr_data_i;
    end
  end

  // Read port 1: x0 reads zero, otherwise bypass or array contents.
  always_comb begin
    rd_data_1_o = '0;
    if (rd_register_1_i != '0) begin
      if (BYPASS && wr_en && (wr_register_i == rd_register_1_i)) begin
        rd_data_1_o = wr_data_i;
      end else begin
        rd_data_1_o = regs_q[rd_register_1_i];
      end
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    rd_data_2_o = '0;
    if (rd_register_2_i != '0) begin
      if (BYPASS && wr_en && (wr_register_i == rd_register_2_i)) begin
        rd_data_2_o = wr_data_i;
      end else begin
        rd_data_2_o = regs_q[rd_register_2_i];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by
// randomized traffic, compared against an array-based reference model.
module tb_register_file;

  logic        clk;
  logic        reset_i;
  logic        reg_write_i;
  logic [4:0]  rd_register_1_i;
  logic [4:0]  rd_register_2_i;
  logic [4:0]  wr_register_i;
  logic [31:0] wr_data_i;
  logic [31:0] rd_data_1_o;
  logic [31:0] rd_data_2_o;

  int tests;
  int fails;

  logic [31:0] model [32];
  bit          model_valid;

  register_file dut (
    .clock_i         (clk),
    .reset_i         (reset_i),
    .reg_write_i     (reg_write_i),
    .rd_register_1_i (rd_register_1_i),
    .rd_register_2_i (rd_register_2_i),
    .wr_register_i   (wr_register_i),
    .wr_data_i       (wr_data_i),
    .rd_data_1_o     (rd_data_1_o),
    .rd_data_2_o     (rd_data_2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value given the current inputs and committed contents.
  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (reg_write_i && !reset_i && wr_register_i != 5'd0 && wr_register_i == idx)
      return wr_data_i;
    return model[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus: check reads before and after the edge.
  task automatic step(input bit rst, input bit we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    reset_i         = rst;
    reg_write_i     = we;
    wr_register_i   = wr;
    wr_data_i       = wd;
    rd_register_1_i = r1;
    rd_register_2_i = r2;
    #1;
    if (model_valid) begin
      check("pre_rd1", rd_data_1_o, exp_rd(r1));
      check("pre_rd2", rd_data_2_o, exp_rd(r2));
    end
    @(posedge clk);
    if (rst) begin
      foreach (model[i]) model[i] = 32'h0;
      model_valid = 1'b1;
    end else if (we && wr != 5'd0) begin
      model[wr] = wd;
    end
    #1;
    if (model_valid) begin
      check("post_rd1", rd_data_1_o, exp_rd(r1));
      check("post_rd2", rd_data_2_o, exp_rd(r2));
    end
    @(negedge clk);
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    model_valid = 1'b0;
    reset_i         = 1'b1;
    reg_write_i     = 1'b0;
    wr_register_i   = 5'd0;
    wr_data_i       = 32'h0;
    rd_register_1_i = 5'd0;
    rd_register_2_i = 5'd0;
    @(negedge clk);

    // Reset held for two edges, then x1/x2 read zero.
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    check("reset_x1", rd_data_1_o, 32'h0000_0000);
    check("reset_x2", rd_data_2_o, 32'h0000_0000);

    // Basic writes and cross-port reads.
    step(1'b0, 1'b1, 5'd1, 32'h5555_5555, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd2, 32'hAAAA_AAAA, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd1);
    check("wr_x2", rd_data_1_o, 32'hAAAA_AAAA);
    check("wr_x1", rd_data_2_o, 32'h5555_5555);

    // Write enable low leaves contents untouched.
    step(1'b0, 1'b0, 5'd1, 32'hAAAA_AAAA, 5'd1, 5'd2);
    step(1'b0, 1'b0, 5'd1, 32'hAAAA_AAAA, 5'd1, 5'd2);
    check("nowe_x1", rd_data_1_o, 32'h5555_5555);
    check("nowe_x2", rd_data_2_o, 32'hAAAA_AAAA);

    // Writes to x0 are discarded; x0 always reads zero.
    reset_i = 1'b0; reg_write_i = 1'b1; wr_register_i = 5'd0;
    wr_data_i = 32'hFFFF_FFFF; rd_register_1_i = 5'd0; rd_register_2_i = 5'd0;
    #1;
    check("x0_pre", rd_data_1_o, 32'h0000_0000);
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    check("x0_post", rd_data_1_o, 32'h0000_0000);

    // Bypass on both ports, then held after the write commits.
    reset_i = 1'b0; reg_write_i = 1'b1; wr_register_i = 5'd5;
    wr_data_i = 32'h1234_5678; rd_register_1_i = 5'd5; rd_register_2_i = 5'd5;
    #1;
    check("byp_rd1", rd_data_1_o, 32'h1234_5678);
    check("byp_rd2", rd_data_2_o, 32'h1234_5678);
    step(1'b0, 1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
    step(1'b0, 1'b0, 5'd5, 32'h0, 5'd5, 5'd5);
    check("byp_hold1", rd_data_1_o, 32'h1234_5678);
    check("byp_hold2", rd_data_2_o, 32'h1234_5678);

    // Reset beats a simultaneous write; no bypass while in reset.
    reset_i = 1'b1; reg_write_i = 1'b1; wr_register_i = 5'd3;
    wr_data_i = 32'hDEAD_BEEF; rd_register_1_i = 5'd3; rd_register_2_i = 5'd3;
    #1;
    check("rst_nobyp", rd_data_1_o, 32'h0000_0000);
    step(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd5);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
    check("rst_x3", rd_data_1_o, 32'h0000_0000);
    check("rst_x5", rd_data_2_o, 32'h0000_0000);
    for (int i = 0; i < 32; i++) begin
      rd_register_1_i = 5'(i);
      rd_register_2_i = 5'(31 - i);
      #1;
      check("rst_all1", rd_data_1_o, 32'h0000_0000);
      check("rst_all2", rd_data_2_o, 32'h0000_0000);
    end
    @(negedge clk);

    // Randomized traffic with occasional resets and forced read/write hits.
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  wr, r1, r2;
      logic [31:0] wd;
      bit          rst, we;
      rst = ($urandom_range(0, 24) == 0);
      we  = 1'($urandom_range(0, 1));
      wr  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      r1  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      step(rst, we, wr, wd, r1, r2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
